fft_frame_buffer: RTL
=====================

# fft_frame_buffer

Ping-pong frame buffer between the decimator and the FFT core. It collects decimated samples into frames of DEPTH words, alternating between two banks. Each completed frame is presented to the FFT as a random-access, read-only bank, while the other bank keeps filling. Its `in_valid` input connects directly to the decimator's `new_sample` strobe, and `in_data` to the decimator's `data_out`.

## Interface

**Parameters**
- `WIDTH`, default 8: sample width in bits.
- `DEPTH`, default 256: samples per frame. Must be a power of two and at least 2. Address width is `AW = $clog2(DEPTH)`.

**Ports**
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  single-cycle sample strobe, from the decimator's `new_sample`.
- `in_data`  in  WIDTH  sample value, sampled when `in_valid` is high.
- `frame_ready`  out  1  high while the read bank holds a complete frame.
- `frame_bank`  out  1  index (0 or 1) of the current read bank.
- `rd_addr`  in  AW  read address within the read bank.
- `rd_data`  out  WIDTH  registered read data.
- `frame_done`  in  1  consumer pulse: finished with the current frame, release the bank.
- `overflow`  out  1  sticky flag: a sample arrived while no bank was free.

## Operation

**State**
- Registers: `wr_bank`, `wr_ptr[AW-1:0]`, `rd_bank`, `full[1:0]`, `overflow`.
- Storage: 2×DEPTH×WIDTH memory, inferable as block RAM. Memory contents are not reset.

**Write side**, evaluated on each edge with `in_valid` = 1:
- If `full[wr_bank]` = 1: the sample is dropped, `overflow` is set to 1, and `wr_ptr` and `wr_bank` are unchanged.
- Otherwise: write `in_data` to `mem[wr_bank][wr_ptr]`.
  - If `wr_ptr` = DEPTH-1: set `full[wr_bank]`, toggle `wr_bank`, and clear `wr_ptr` to 0.
  - Else: increment `wr_ptr`.
- With `in_valid` = 0, there is no write-side change.

**Read side**
- `frame_ready` = `full[rd_bank]`, decoded combinationally from registers.
- `frame_bank` = `rd_bank`.
- `rd_data` is loaded from `mem[rd_bank][rd_addr]` every cycle, regardless of `frame_ready`. The data is only meaningful while `frame_ready` = 1.
- A full bank is never written, so frame contents are stable for as long as the bank stays full.
- `frame_done` while `frame_ready` = 1: clear `full[rd_bank]` and toggle `rd_bank`.
- `frame_done` while `frame_ready` = 0: ignored, no state change.

**Simultaneous events** (all decisions use pre-edge register values)
- Fill completes on one bank and `frame_done` releases the other bank in the same cycle: both take effect.
- `frame_done` frees bank B while `in_valid` arrives with `wr_bank` = B still full: that sample is dropped and `overflow` is set. The next sample is written to address 0 of bank B.

**Overflow**
- Sticky; cleared only by `reset`.
- Dropped samples are lost and do not shift the frame alignment.

**Reset** (asynchronous, any time)
- `wr_bank`, `wr_ptr`, `rd_bank`, `full`, `overflow`, and `rd_data` all go to 0.
- Resulting outputs: `frame_ready` = 0, `frame_bank` = 0, `rd_data` = 0, `overflow` = 0.
- A partially filled or unread frame is discarded. The next accepted sample lands at bank 0, address 0.

## Timing

- Read latency is 1 cycle: `rd_addr` presented in cycle n gives `rd_data` valid in cycle n+1. Back-to-back addresses give one word per cycle.
- `frame_ready` rises in the cycle after the edge that captures the DEPTH-th sample of a frame.
- After `frame_done` is sampled, the following cycle shows the new `frame_bank`:
  - `frame_ready` stays high if the other bank is already full, otherwise it drops.
- `overflow` rises the cycle after the dropped strobe.
- `in_valid` may be asserted on consecutive cycles or with arbitrary gaps. There is no back-pressure to the decimator.
- Throughput: one sample per cycle with no loss, provided each frame is released within DEPTH input strobes of becoming ready.

## Test plan

All scenarios use DEPTH = 4 and WIDTH = 8.

1. **Basic fill and read.** Reset, then strobe 1, 2, 3, 4 on consecutive cycles → `frame_ready` = 1 and `frame_bank` = 0 the cycle after the 4th strobe. `rd_addr` 0..3 returns 1, 2, 3, 4 one cycle later.
2. **Bank switch.** Hold bank 0 unreleased and strobe 5..8 → `full` = 11. Pulse `frame_done` → next cycle `frame_bank` = 1 and `frame_ready` stays 1. Reads return 5, 6, 7, 8.
3. **Overflow.** With both banks full, strobe 9 → `overflow` = 1 and 9 is stored nowhere. Pulse `frame_done`, then strobe 10..13 → bank 0 reads back 10, 11, 12, 13 and `overflow` remains 1.
4. **Ignored release.** With `frame_ready` = 0, pulse `frame_done` → `frame_bank`, `full` and `frame_ready` unchanged. A subsequent 4-sample fill lands in bank 0.
5. **Reset mid-fill.** Strobe 2 samples, then assert `reset` asynchronously between clock edges → all outputs 0 immediately. Then strobe 20..23 → frame in bank 0 reads 20, 21, 22, 23.
6. **Decimator-paced input.** Assert `in_valid` every 4th cycle with values 0x10..0x17 → two frames read back as 0x10–0x13 and 0x14–0x17, with no overflow.

Source files
------------

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: fills one bank with DEPTH decimated samples while the
// other bank is held read-only for the FFT core, which releases it with frame_done.
module fft_frame_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             frame_ready,
    output logic             frame_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             frame_done,
    output logic             overflow
);

    logic          wr_bank, wr_bank_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic [1:0]    full, full_nxt;
    logic          overflow_nxt;
    logic          wr_en;
    logic          release_en;

    logic [WIDTH-1:0] mem [2*DEPTH];

    assign frame_ready = full[rd_bank];
    assign frame_bank  = rd_bank;

    // All decisions use pre-edge state; a filling bank is never full and the
    // read bank is full when released, so the two full-bit updates never collide.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        wr_bank_nxt  = wr_bank;
        wr_ptr_nxt   = wr_ptr;
        rd_bank_nxt  = rd_bank;
        full_nxt     = full;
        overflow_nxt = overflow;

        wr_en      = in_valid && !full[wr_bank];
        release_en = frame_done && full[rd_bank];

        if (in_valid && full[wr_bank]) begin
            overflow_nxt = 1'b1;
        end

        if (wr_en) begin
            if (wr_ptr == AW'(DEPTH - 1)) begin
                full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt       = ~wr_bank;
                wr_ptr_nxt        = '0;
            end else begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
        end

        if (release_en) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            overflow <= 1'b0;
        end else begin
            wr_bank  <= wr_bank_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_bank  <= rd_bank_nxt;
            full     <= full_nxt;
            overflow <= overflow_nxt;
        end
    end

    // NOTE: the sample array has no reset so it maps onto block RAM; stale
    // contents are harmless because reads only matter while frame_ready is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_ptr}] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule
